// File: rtl/lrelu_cfg_sequencer.sv
// Front-end sequencer for the lrelu engine: splits an AXIS stream into coefficient
// config loads (tuser[I_CONFIG] header + N beats) and data packets forwarded with zero latency.
module lrelu_cfg_sequencer #(
  parameter int DATA_WIDTH     = 256,
  parameter int TUSER_WIDTH    = 4,
  parameter int CFG_ADDR_WIDTH = 8,
  parameter int I_CONFIG       = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                      s_axis_tlast,

  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                      m_axis_tlast,

  output logic                      cfg_wr_en,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [DATA_WIDTH-1:0]     cfg_wr_data,

  output logic                      cfg_done,
  output logic                      err_cfg
);

  typedef enum logic [2:0] {IDLE, CFG, DRAIN, SETTLE, PASS} state_t;

  state_t                    state_reg;
  logic [CFG_ADDR_WIDTH-1:0] n_m1_reg;
  logic [CFG_ADDR_WIDTH-1:0] cnt_reg;
  logic                      cfg_wr_en_reg;
  logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr_reg;
  logic [DATA_WIDTH-1:0]     cfg_wr_data_reg;
  logic                      cfg_done_reg;
  logic                      err_cfg_reg;

  logic is_cfg;
  logic s_ready;
  logic m_valid;
  logic accept;
  logic cnt_last;

  // Handshake steering. In IDLE the first beat is classified on the fly: a header
  // is always taken, a data beat is forwarded exactly as in PASS.
  always_comb begin
    is_cfg  = s_axis_tuser[I_CONFIG];
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        s_ready = (s_axis_tvalid & is_cfg) | m_axis_tready;
        m_valid = s_axis_tvalid & ~is_cfg;
      end
      CFG, DRAIN: s_ready = 1'b1;
      PASS: begin
        s_ready = m_axis_tready;
        m_valid = s_axis_tvalid;
      end
      default: begin
        s_ready = 1'b0;
        m_valid = 1'b0;
      end
    endcase
  end

  assign s_axis_tready = s_ready & aresetn;
  assign m_axis_tvalid = m_valid & aresetn;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign cnt_last = (cnt_reg == n_m1_reg);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      n_m1_reg        <= '0;
      cnt_reg         <= '0;
      cfg_wr_en_reg   <= 1'b0;
      cfg_wr_addr_reg <= '0;
      cfg_wr_data_reg <= '0;
      cfg_done_reg    <= 1'b0;
      err_cfg_reg     <= 1'b0;
    end else begin
      cfg_wr_en_reg <= 1'b0;
      cfg_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_cfg) begin
              n_m1_reg <= s_axis_tdata[CFG_ADDR_WIDTH-1:0];
              cnt_reg  <= '0;
              if (s_axis_tlast) err_cfg_reg <= 1'b1;
              else              state_reg   <= CFG;
            end else if (!s_axis_tlast) begin
              state_reg <= PASS;
            end
          end
        end
        CFG: begin
          if (accept) begin
            cfg_wr_en_reg   <= 1'b1;
            cfg_wr_addr_reg <= cnt_reg;
            cfg_wr_data_reg <= s_axis_tdata;
            // The N_M1 compare ends the load before the counter could wrap.
            if (cnt_last) begin
              cfg_done_reg <= 1'b1;
              if (s_axis_tlast) begin
                state_reg <= SETTLE;
              end else begin
                err_cfg_reg <= 1'b1;
                state_reg   <= DRAIN;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
              if (s_axis_tlast) begin
                err_cfg_reg <= 1'b1;
                state_reg   <= IDLE;
              end
            end
          end
        end
        DRAIN: begin
          if (accept && s_axis_tlast) state_reg <= SETTLE;
        end
        SETTLE: state_reg <= IDLE;
        PASS: begin
          if (accept && s_axis_tlast) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cfg_wr_en   = cfg_wr_en_reg;
  assign cfg_wr_addr = cfg_wr_addr_reg;
  assign cfg_wr_data = cfg_wr_data_reg;
  assign cfg_done    = cfg_done_reg;
  assign err_cfg     = err_cfg_reg;

endmodule

// File: tb/tb_lrelu_cfg_sequencer.sv
// Scoreboard bench for lrelu_cfg_sequencer: directed packets push expected beats/writes,
// an independent negedge monitor pops and compares whenever the DUT presents them.
module tb_lrelu_cfg_sequencer;
  localparam int DW = 32;
  localparam int UW = 4;
  localparam int AW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic          cfg_done;
  logic          err_cfg;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit tog_en = 1'b0;

  typedef struct { logic [DW-1:0] d; logic [UW-1:0] u; logic l; } beat_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic done; } wr_t;
  beat_t exp_m[$];
  wr_t   exp_w[$];

  lrelu_cfg_sequencer #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .CFG_ADDR_WIDTH(AW), .I_CONFIG(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_done(cfg_done), .err_cfg(err_cfg)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: steady 1, or toggling every cycle while tog_en is set.
  initial forever begin
    @(posedge aclk); #1;
    if (tog_en) m_axis_tready = ~m_axis_tready;
    else        m_axis_tready = 1'b1;
  end

  // Monitor: every presented m-beat or cfg write is matched against the queues.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_m.size() == 0) begin
          chk("unexpected_m_beat", {32'h0, m_axis_tdata}, 64'h0);
        end else begin
          beat_t b;
          b = exp_m.pop_front();
          $display("m beat: data=0x%0h user=0x%0h last=%0b", m_axis_tdata, m_axis_tuser, m_axis_tlast);
          chk("m_tdata", {32'h0, m_axis_tdata}, {32'h0, b.d});
          chk("m_tuser", {60'h0, m_axis_tuser}, {60'h0, b.u});
          chk("m_tlast", {63'h0, m_axis_tlast}, {63'h0, b.l});
        end
      end
      if (cfg_wr_en) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_cfg_wr", {56'h0, cfg_wr_addr}, 64'hFFFF);
        end else begin
          wr_t w;
          w = exp_w.pop_front();
          $display("cfg wr: addr=%0d data=0x%0h done=%0b", cfg_wr_addr, cfg_wr_data, cfg_done);
          chk("cfg_addr", {56'h0, cfg_wr_addr}, {56'h0, w.a});
          chk("cfg_data", {32'h0, cfg_wr_data}, {32'h0, w.d});
          chk("cfg_done", {63'h0, cfg_done}, {63'h0, w.done});
        end
      end else if (cfg_done) begin
        chk("stray_cfg_done", 64'h1, 64'h0);
      end
    end
  end

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    bit acc;
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    n = 0;
    forever begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'h0, 64'h1);
        break;
      end
    end
  endtask

  task automatic idle_bus();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'hDEAD_BEEF;
    s_axis_tuser  = 4'hF;
    s_axis_tlast  = 1'b1;
  endtask

  task automatic cfg_beat(input logic [DW-1:0] d, input logic l, input logic [AW-1:0] a,
                          input logic done);
    exp_w.push_back('{a: a, d: d, done: done});
    send(d, 4'h0, l);
  endtask

  task automatic data_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    exp_m.push_back('{d: d, u: u, l: l});
    send(d, u, l);
  endtask

  // After the final accepted beat of a load: one cycle with tready low, then ready again.
  task automatic check_settle(input string tag);
    idle_bus();
    @(negedge aclk);
    chk({tag, "_settle_tready"}, {63'h0, s_axis_tready}, 64'h0);
    chk({tag, "_settle_tvalid"}, {63'h0, m_axis_tvalid}, 64'h0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk({tag, "_idle_tready"}, {63'h0, s_axis_tready}, 64'h1);
    @(posedge aclk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},  {63'h0, cfg_wr_en}, 64'h0);
    chk({tag, "_addr"},   {56'h0, cfg_wr_addr}, 64'h0);
    chk({tag, "_data"},   {32'h0, cfg_wr_data}, 64'h0);
    chk({tag, "_done"},   {63'h0, cfg_done}, 64'h0);
    chk({tag, "_err"},    {63'h0, err_cfg}, 64'h0);
    chk({tag, "_tready"}, {63'h0, s_axis_tready}, 64'h0);
    chk({tag, "_tvalid"}, {63'h0, m_axis_tvalid}, 64'h0);
  endtask

  initial begin
    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("por");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;
    @(posedge aclk); #1;

    // Normal 4-coefficient load
    send(32'h0000_0003, 4'h1, 1'b0);
    cfg_beat(32'hA000_0000, 1'b0, 8'd0, 1'b0);
    cfg_beat(32'hA111_1111, 1'b0, 8'd1, 1'b0);
    cfg_beat(32'hA222_2222, 1'b0, 8'd2, 1'b0);
    cfg_beat(32'hA333_3333, 1'b1, 8'd3, 1'b1);
    check_settle("load4");
    chk("load4_err", {63'h0, err_cfg}, 64'h0);

    // 5-beat data packet with downstream ready toggling
    tog_en = 1'b1;
    data_beat(32'h1000_0001, 4'h6, 1'b0);
    data_beat(32'h1000_0002, 4'h2, 1'b0);
    data_beat(32'h1000_0003, 4'hA, 1'b0);
    data_beat(32'h1000_0004, 4'h4, 1'b0);
    data_beat(32'h1000_0005, 4'hE, 1'b1);
    idle_bus();
    tog_en = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Short config: tlast on the 2nd of 4 expected beats
    send(32'h0000_0003, 4'h1, 1'b0);
    cfg_beat(32'hB000_0000, 1'b0, 8'd0, 1'b0);
    cfg_beat(32'hB111_1111, 1'b1, 8'd1, 1'b0);
    idle_bus();
    @(negedge aclk);
    chk("short_err", {63'h0, err_cfg}, 64'h1);
    @(posedge aclk); #1;
    data_beat(32'h2000_0001, 4'h0, 1'b0);
    data_beat(32'h2000_0002, 4'h8, 1'b1);
    idle_bus();
    @(posedge aclk); #1;

    // Long config: N_M1=1 but 4 beats, extra beats drained
    send(32'h0000_0001, 4'h1, 1'b0);
    cfg_beat(32'hC000_0000, 1'b0, 8'd0, 1'b0);
    cfg_beat(32'hC111_1111, 1'b0, 8'd1, 1'b1);
    send(32'hC222_2222, 4'h0, 1'b0);
    send(32'hC333_3333, 4'h0, 1'b1);
    check_settle("long");
    chk("long_err", {63'h0, err_cfg}, 64'h1);

    // Reset in the middle of a load, then a 1-beat load
    send(32'h0000_0003, 4'h1, 1'b0);
    cfg_beat(32'hD000_0000, 1'b0, 8'd0, 1'b0);
    cfg_beat(32'hD111_1111, 1'b0, 8'd1, 1'b0);
    idle_bus();
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("midrst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send(32'h0000_0000, 4'h1, 1'b0);
    cfg_beat(32'hE555_5555, 1'b1, 8'd0, 1'b1);
    check_settle("one");
    chk("one_err", {63'h0, err_cfg}, 64'h0);

    repeat (3) @(posedge aclk);
    chk("exp_m_left", exp_m.size(), 64'h0);
    chk("exp_w_left", exp_w.size(), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
